// File: rtl/typing_game_ctrl.sv
// -----------------------------------------------------------------------------
// typing_game_ctrl
//
// Game sequencer for the speed-typer word datapath. It arms word loads
// (enable_next_level) and compares each PS/2 make code against the current
// target byte (comparison_data). On a match it pulses get_next_character to
// shift the datapath to the next character. It also keeps per-word progress,
// the error count, the score and a per-word countdown, and ends the game in
// WIN or LOSE.
//
// Ports:
//   clk                 in  1   clock
//   resetn              in  1   synchronous, active-low reset
//   start               in  1   one-cycle pulse, begins the game from IDLE
//   key_valid           in  1   one-cycle strobe, key_code holds a new make code
//   key_code            in  8   PS/2 set-2 make code
//   comparison_data     in  8   current target character from the datapath
//   num_char            in  8   length of the current word (3..12)
//   get_next_character  out 1   one-cycle pulse, shift to next character
//   enable_next_level   out 1   one-cycle pulse, load/advance the word
//   level               out 5   completed-word count (current word index)
//   chars_typed         out 4   correct characters typed in the current word
//   errors              out 8   total mismatches (saturating)
//   score               out 16  accumulated score (wraps)
//   time_left           out 8   seconds remaining for the current word
//   game_over           out 1   high in LOSE
//   game_win            out 1   high in WIN
//   state_dbg           out 3   current FSM state (debug observation)
//
// Handshake: key_valid is a single-cycle strobe with no back-pressure; a
// strobe is consumed only in PLAY and silently dropped in every other state.
// All outputs are registered or decoded from the state register.
// -----------------------------------------------------------------------------
module typing_game_ctrl #(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int LEVEL_TIME    = 30,
   parameter int NUM_WORDS     = 16,
   parameter int MAX_ERRORS    = 10
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        key_valid,
   input  logic [7:0]  key_code,
   input  logic [7:0]  comparison_data,
   input  logic [7:0]  num_char,
   output logic        get_next_character,
   output logic        enable_next_level,
   output logic [4:0]  level,
   output logic [3:0]  chars_typed,
   output logic [7:0]  errors,
   output logic [15:0] score,
   output logic [7:0]  time_left,
   output logic        game_over,
   output logic        game_win,
   output logic [2:0]  state_dbg
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ARM     = 3'd1;
   localparam logic [2:0] S_LOAD    = 3'd2;
   localparam logic [2:0] S_PLAY    = 3'd3;
   localparam logic [2:0] S_MATCH   = 3'd4;
   localparam logic [2:0] S_ADVANCE = 3'd5;
   localparam logic [2:0] S_WIN     = 3'd6;
   localparam logic [2:0] S_LOSE    = 3'd7;

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] TICK_MAX   = PW'(TICKS_PER_SEC - 1);
   localparam logic [7:0]    LT_INIT    = 8'(LEVEL_TIME);
   localparam logic [7:0]    ERR_LIMIT  = 8'(MAX_ERRORS);
   localparam logic [4:0]    WORD_LIMIT = 5'(NUM_WORDS);

   logic [2:0]    state, state_nxt;
   logic [1:0]    load_cnt;
   logic [PW-1:0] presc;
   logic          tick;
   logic          counting;
   logic          key_match;
   logic [7:0]    errors_inc;
   logic          unused_num_char_hi;

   // Only the low nibble of the word length is meaningful (max 12).
   assign unused_num_char_hi = ^num_char[7:4];

   assign counting   = (state == S_PLAY) || (state == S_MATCH);
   assign tick       = counting && (presc == TICK_MAX);
   assign key_match  = key_valid && (key_code == comparison_data);
   assign errors_inc = (errors == 8'hFF) ? 8'hFF : errors + 8'd1;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (start) state_nxt = S_ARM;
         S_ARM:     state_nxt = S_LOAD;
         S_LOAD:    if (load_cnt == 2'd2) state_nxt = S_PLAY;
         S_PLAY: begin
            // A matching key wins over the last second running out.
            if (key_match)
               state_nxt = S_MATCH;
            else if (tick && (time_left == 8'd1))
               state_nxt = S_LOSE;
            // time_left can only sit at 0 here after a match took priority
            // over the final tick; the word is then out of time.
            else if (time_left == 8'd0)
               state_nxt = S_LOSE;
            else if (key_valid && (errors_inc == ERR_LIMIT))
               state_nxt = S_LOSE;
         end
         S_MATCH: begin
            if (tick && (time_left == 8'd1))
               state_nxt = S_LOSE;
            else if (chars_typed == num_char[3:0])
               state_nxt = S_ADVANCE;
            else
               state_nxt = S_PLAY;
         end
         S_ADVANCE: state_nxt = ((level + 5'd1) == WORD_LIMIT) ? S_WIN : S_ARM;
         default:   state_nxt = state;   // WIN and LOSE are terminal
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state       <= S_IDLE;
         load_cnt    <= 2'd0;
         presc       <= '0;
         level       <= 5'd0;
         chars_typed <= 4'd0;
         errors      <= 8'd0;
         score       <= 16'd0;
         time_left   <= 8'd0;
      end else begin
         state <= state_nxt;
         case (state)
            S_ARM: begin
               time_left   <= LT_INIT;
               chars_typed <= 4'd0;
               presc       <= '0;
               load_cnt    <= 2'd0;
            end
            S_LOAD: load_cnt <= load_cnt + 2'd1;
            S_PLAY: begin
               if (key_match) begin
                  chars_typed <= chars_typed + 4'd1;
                  score       <= score + 16'd1;
               end else if (key_valid) begin
                  errors <= errors_inc;
               end
            end
            S_ADVANCE: begin
               score <= score + {8'd0, time_left};
               level <= level + 5'd1;
            end
            default: ;
         endcase
         // Countdown prescaler runs only while the player is typing.
         if (counting) begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick && (time_left != 8'd0))
               time_left <= time_left - 8'd1;
         end
      end
   end

   assign get_next_character = (state == S_MATCH);
   assign enable_next_level  = (state == S_ARM);
   assign game_over          = (state == S_LOSE);
   assign game_win           = (state == S_WIN);
   assign state_dbg          = state;

endmodule

// File: tb/tb_typing_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_typing_game_ctrl
//
// Two controller instances share the stimulus: dut_a (2 words, 2 errors to
// lose, 20-cycle seconds) runs the gameplay scenarios, dut_b (4-cycle
// seconds, 2-second words) runs the countdown scenario. A small word
// datapath model feeds comparison_data/num_char from enable_next_level and
// get_next_character of dut_a.
// -----------------------------------------------------------------------------
module tb_typing_game_ctrl;

   localparam int T_A  = 20;
   localparam int LT_A = 10;
   localparam int NW_A = 2;
   localparam int ME_A = 2;
   localparam int T_B  = 4;
   localparam int LT_B = 2;
   localparam logic [2:0] IDLE_S = 3'd0;
   localparam logic [2:0] PLAY_S = 3'd3;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic        key_valid = 1'b0;
   logic [7:0]  key_code = 8'd0;
   logic [7:0]  comparison_data;
   logic [7:0]  num_char;

   logic        gnc_a, enl_a, over_a, win_a;
   logic [4:0]  level_a;
   logic [3:0]  chars_a;
   logic [7:0]  errors_a, time_a;
   logic [15:0] score_a;
   logic [2:0]  st_a;

   logic        gnc_b, enl_b, over_b, win_b;
   logic [4:0]  level_b;
   logic [3:0]  chars_b;
   logic [7:0]  errors_b, time_b;
   logic [15:0] score_b;
   logic [2:0]  st_b;

   always #5 clk = ~clk;

   typing_game_ctrl #(.TICKS_PER_SEC(T_A), .LEVEL_TIME(LT_A),
                      .NUM_WORDS(NW_A), .MAX_ERRORS(ME_A)) dut_a (
      .clk(clk), .resetn(resetn), .start(start), .key_valid(key_valid),
      .key_code(key_code), .comparison_data(comparison_data), .num_char(num_char),
      .get_next_character(gnc_a), .enable_next_level(enl_a), .level(level_a),
      .chars_typed(chars_a), .errors(errors_a), .score(score_a),
      .time_left(time_a), .game_over(over_a), .game_win(win_a), .state_dbg(st_a));

   typing_game_ctrl #(.TICKS_PER_SEC(T_B), .LEVEL_TIME(LT_B)) dut_b (
      .clk(clk), .resetn(resetn), .start(start), .key_valid(key_valid),
      .key_code(key_code), .comparison_data(comparison_data), .num_char(num_char),
      .get_next_character(gnc_b), .enable_next_level(enl_b), .level(level_b),
      .chars_typed(chars_b), .errors(errors_b), .score(score_b),
      .time_left(time_b), .game_over(over_b), .game_win(win_b), .state_dbg(st_b));

   // ---------------- word datapath model ----------------
   logic [7:0] words [0:1][0:11];
   int lens [0:1];
   int widx = 0;
   int cidx = 0;
   int cur  = 0;

   always @(posedge clk) begin
      if (!resetn) begin
         widx <= 0; cidx <= 0; cur <= 0;
      end else if (enl_a) begin
         cur  <= (widx > 1) ? 1 : widx;
         widx <= widx + 1;
         cidx <= 0;
      end else if (gnc_a) begin
         cidx <= cidx + 1;
      end
   end

   assign comparison_data = words[cur][(cidx > 11) ? 11 : cidx];
   assign num_char        = 8'(lens[cur]);

   // ---------------- pulse monitor ----------------
   int gnc_cnt = 0;
   int overlap_cnt = 0;
   always @(negedge clk) begin
      if (resetn) begin
         if (gnc_a) gnc_cnt++;
         if (gnc_a && enl_a) overlap_cnt++;
      end
   end

   // ---------------- scoreboard / model state ----------------
   int n_checks = 0;
   int n_fail = 0;
   logic [15:0] exp_q[$];
   int exp_score, exp_level, exp_errors, err_budget;

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn = 1'b0; start = 1'b0; key_valid = 1'b0;
      step(); step();
      resetn = 1'b1;
   endtask

   task automatic gen_word(input int w, input int len);
      lens[w] = len;
      for (int i = 0; i < 12; i++) words[w][i] = 8'($urandom_range(1, 255));
   endtask

   // From the ARM cycle: three LOAD cycles, optionally with a key held.
   task automatic drive_load(input bit press);
      step();
      if (press) begin
         key_valid = 1'b1;
         key_code  = comparison_data;
      end
      step(); step(); step();
      key_valid = 1'b0;
   endtask

   // From the first PLAY cycle of word w: type it, possibly with one wrong key.
   task automatic type_word(input int w);
      int k;
      int bonus;
      k = 0;
      for (int i = 0; i < lens[w]; i++) begin
         repeat ($urandom_range(0, 2)) begin step(); k++; end
         if (err_budget > 0 && $urandom_range(0, 3) == 0) begin
            key_valid = 1'b1;
            key_code  = words[w][i] ^ 8'($urandom_range(1, 255));
            step(); k++;
            key_valid = 1'b0;
            exp_errors++; err_budget--;
            n_checks++;
            if (errors_a !== 8'(exp_errors) || gnc_a !== 1'b0) begin
               n_fail++;
               $display("FAIL wrong_key: errors=%0d gnc=%0b expected errors=%0d gnc=0",
                        errors_a, gnc_a, exp_errors);
            end
         end
         key_valid = 1'b1;
         key_code  = words[w][i];
         step(); k++;
         key_valid = 1'b0;
         exp_score++;
         n_checks++;
         if (gnc_a !== 1'b1 || chars_a !== 4'(i + 1) || score_a !== 16'(exp_score)) begin
            n_fail++;
            $display("FAIL match: gnc=%0b chars=%0d score=%0d expected 1 %0d %0d",
                     gnc_a, chars_a, score_a, i + 1, exp_score);
         end
         n_checks++;
         if (time_a !== 8'(LT_A - k / T_A)) begin
            n_fail++;
            $display("FAIL time_left: got %0d expected %0d", time_a, LT_A - k / T_A);
         end
         step(); k++;
         n_checks++;
         if (gnc_a !== 1'b0) begin
            n_fail++;
            $display("FAIL gnc_width: gnc=%0b expected 0", gnc_a);
         end
      end
      // ADVANCE: completion bonus is the seconds still left on the clock.
      bonus = LT_A - k / T_A;
      exp_score += bonus;
      exp_level++;
      exp_q.push_back(16'(exp_score));
      step();
      n_checks++;
      if (level_a !== 5'(exp_level) || score_a !== exp_q.pop_front()) begin
         n_fail++;
         $display("FAIL word_done: level=%0d score=%0d expected %0d %0d",
                  level_a, score_a, exp_level, exp_score);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      resetn = 1'b0;
      start  = 1'b1;
      step(); step();
      start = 1'b0;
      n_checks++;
      if ({gnc_a, enl_a, level_a, chars_a, errors_a, score_a, time_a, over_a, win_a} !== '0
          || st_a !== IDLE_S) begin
         n_fail++;
         $display("FAIL reset_values: lvl=%0d ch=%0d err=%0d sc=%0d t=%0d st=%0d expected all 0",
                  level_a, chars_a, errors_a, score_a, time_a, st_a);
      end
      resetn = 1'b1;
      step();
      n_checks++;
      if (st_a !== IDLE_S || enl_a !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_hold: st=%0d enl=%0b expected 0 0", st_a, enl_a);
      end
   endtask

   task automatic play_game(input bit fixed_first, input bit allow_err);
      int g0;
      do_reset();
      exp_score = 0; exp_level = 0; exp_errors = 0;
      err_budget = allow_err ? 1 : 0;
      gen_word(0, $urandom_range(3, 12));
      gen_word(1, $urandom_range(3, 12));
      if (fixed_first) begin
         lens[0] = 3;
         words[0][0] = 8'h24; words[0][1] = 8'h21; words[0][2] = 8'h2B;
      end
      g0 = gnc_cnt;
      start = 1'b1;
      step();
      start = 1'b0;
      n_checks++;
      if (enl_a !== 1'b1 || gnc_a !== 1'b0) begin
         n_fail++;
         $display("FAIL first_enl: enl=%0b gnc=%0b expected 1 0", enl_a, gnc_a);
      end
      drive_load(1'b1);
      n_checks++;
      if (errors_a !== 8'd0 || chars_a !== 4'd0 || gnc_cnt !== g0 || st_a !== PLAY_S) begin
         n_fail++;
         $display("FAIL load_ignore: err=%0d ch=%0d gnc_pulses=%0d st=%0d expected 0 0 0 %0d",
                  errors_a, chars_a, gnc_cnt - g0, st_a, PLAY_S);
      end
      type_word(0);
      n_checks++;
      if (enl_a !== 1'b1 || win_a !== 1'b0) begin
         n_fail++;
         $display("FAIL second_enl: enl=%0b win=%0b expected 1 0", enl_a, win_a);
      end
      drive_load(1'b0);
      type_word(1);
      n_checks++;
      if (win_a !== 1'b1 || over_a !== 1'b0 || level_a !== 5'(NW_A)) begin
         n_fail++;
         $display("FAIL win: win=%0b over=%0b level=%0d expected 1 0 %0d",
                  win_a, over_a, level_a, NW_A);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      n_checks++;
      if (win_a !== 1'b1 || enl_a !== 1'b0 || level_a !== 5'(NW_A)
          || score_a !== 16'(exp_score) || errors_a !== 8'(exp_errors)) begin
         n_fail++;
         $display("FAIL win_frozen: win=%0b enl=%0b level=%0d score=%0d err=%0d expected 1 0 %0d %0d %0d",
                  win_a, enl_a, level_a, score_a, errors_a, NW_A, exp_score, exp_errors);
      end
      n_checks++;
      if (overlap_cnt !== 0) begin
         n_fail++;
         $display("FAIL pulse_overlap: got %0d expected 0", overlap_cnt);
      end
   endtask

   task automatic test_mismatch();
      logic [7:0] bad;
      do_reset();
      gen_word(0, 5);
      gen_word(1, 4);
      words[0][0] = 8'h2A;
      start = 1'b1; step(); start = 1'b0;
      drive_load(1'b0);
      key_valid = 1'b1; key_code = 8'h1C;
      step();
      key_valid = 1'b0;
      n_checks++;
      if (errors_a !== 8'd1 || gnc_a !== 1'b0 || st_a !== PLAY_S || over_a !== 1'b0
          || chars_a !== 4'd0) begin
         n_fail++;
         $display("FAIL first_mismatch: err=%0d gnc=%0b st=%0d over=%0b ch=%0d expected 1 0 %0d 0 0",
                  errors_a, gnc_a, st_a, over_a, chars_a, PLAY_S);
      end
      key_valid = 1'b1; key_code = 8'h2A;
      step();
      key_valid = 1'b0;
      n_checks++;
      if (gnc_a !== 1'b1 || chars_a !== 4'd1 || score_a !== 16'd1) begin
         n_fail++;
         $display("FAIL match_after_error: gnc=%0b ch=%0d sc=%0d expected 1 1 1",
                  gnc_a, chars_a, score_a);
      end
      step();
      bad = comparison_data ^ 8'($urandom_range(1, 255));
      key_valid = 1'b1; key_code = bad;
      step();
      key_valid = 1'b0;
      n_checks++;
      if (errors_a !== 8'(ME_A) || over_a !== 1'b1) begin
         n_fail++;
         $display("FAIL lose_on_errors: err=%0d over=%0b expected %0d 1", errors_a, over_a, ME_A);
      end
      key_valid = 1'b1; key_code = 8'h55;
      start = 1'b1;
      step();
      key_valid = 1'b0; start = 1'b0;
      step();
      n_checks++;
      if (errors_a !== 8'(ME_A) || over_a !== 1'b1 || score_a !== 16'd1 || enl_a !== 1'b0) begin
         n_fail++;
         $display("FAIL lose_frozen: err=%0d over=%0b sc=%0d enl=%0b expected %0d 1 1 0",
                  errors_a, over_a, score_a, enl_a, ME_A);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      gen_word(0, 6);
      gen_word(1, 6);
      start = 1'b1; step(); start = 1'b0;
      drive_load(1'b0);
      n_checks++;
      if (time_b !== 8'(LT_B) || over_b !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_start: t=%0d over=%0b expected %0d 0", time_b, over_b, LT_B);
      end
      for (int e = 1; e <= 9; e++) begin
         step();
         if (e <= LT_B * T_B) begin
            n_checks++;
            if (time_b !== 8'(LT_B - e / T_B)) begin
               n_fail++;
               $display("FAIL countdown: edge %0d t=%0d expected %0d", e, time_b, LT_B - e / T_B);
            end
         end
         if (e < LT_B * T_B) begin
            n_checks++;
            if (over_b !== 1'b0) begin
               n_fail++;
               $display("FAIL early_lose: edge %0d over=%0b expected 0", e, over_b);
            end
         end
         if (e == LT_B * T_B + 1) begin
            n_checks++;
            if (over_b !== 1'b1 || time_b !== 8'd0) begin
               n_fail++;
               $display("FAIL timeout_lose: over=%0b t=%0d expected 1 0", over_b, time_b);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      gen_word(0, 7);
      gen_word(1, 5);
      start = 1'b1; step(); start = 1'b0;
      drive_load(1'b0);
      key_valid = 1'b1; key_code = comparison_data;
      step();
      key_valid = 1'b0;
      step();
      n_checks++;
      if (chars_a !== 4'd1 || score_a !== 16'd1 || time_a !== 8'(LT_A)) begin
         n_fail++;
         $display("FAIL mid_word: ch=%0d sc=%0d t=%0d expected 1 1 %0d", chars_a, score_a, time_a, LT_A);
      end
      resetn = 1'b0;
      step();
      n_checks++;
      if ({gnc_a, enl_a, level_a, chars_a, errors_a, score_a, time_a, over_a, win_a} !== '0
          || st_a !== IDLE_S) begin
         n_fail++;
         $display("FAIL reset_mid: ch=%0d sc=%0d t=%0d st=%0d expected all 0",
                  chars_a, score_a, time_a, st_a);
      end
      resetn = 1'b1;
   endtask

   initial begin
      test_reset();
      play_game(1'b1, 1'b0);
      test_mismatch();
      test_timeout();
      test_reset_mid();
      for (int g = 0; g < 4; g++) play_game(1'b0, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
